// File: rtl/multicycle_control.sv
// Sequencing controller for the multicycle MIPS core: one micro-step per cycle,
// shared memory port with ready handshake and watchdog, retire counter, illegal-op flag.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 branch_ne,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;
    logic              retire;
    logic              decode_illegal;

    assign state = cur_state;

    // A memory state stalls while mem_ready is low; the watchdog fires at the limit.
    always_comb begin
        waiting = 1'b0;
        if ((cur_state == S_FETCH) || (cur_state == S_MEM_RD) || (cur_state == S_MEM_WR))
            waiting = !mem_ready;
        timeout = waiting && (wait_cnt == WAIT_W'(WAIT_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst)
            cur_state <= S_FETCH;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state     = cur_state;
        decode_illegal = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (timeout)
                    next_state = S_HALT;
                else if (mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    6'h23, 6'h2B: next_state = S_MEM_ADDR;
                    6'h00:        next_state = S_R_EXEC;
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h02:        next_state = S_JUMP;
                    6'h08:        next_state = S_ADDI_EXEC;
                    default: begin
                        next_state     = S_HALT;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  next_state = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (timeout)
                    next_state = S_HALT;
                else if (mem_ready)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WR: begin
                if (timeout)
                    next_state = S_HALT;
                else if (mem_ready)
                    next_state = S_FETCH;
            end
            S_R_EXEC:    next_state = S_R_WB;
            S_R_WB:      next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_HALT;
        endcase
    end

    // Only the final step of an instruction transitions back into FETCH.
    assign retire = (next_state == S_FETCH) && (cur_state != S_FETCH);

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (waiting && (next_state == cur_state))
            wait_cnt <= wait_cnt + WAIT_W'(1);
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            if (decode_illegal)
                illegal_op <= 1'b1;
            if (timeout)
                mem_timeout <= 1'b1;
            if (retire)
                retired <= retired + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:    alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opcode == 6'h05);
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB:   reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized
// instruction stream checked against an instruction-level sequence model.
module tb_multicycle_control;

    logic        clk;
    logic        rst, rst3;
    logic [5:0]  opcode, opcode3;
    logic        mem_ready, mem_ready3;

    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal_op, mem_timeout;
    logic [31:0] retired;

    logic        pc_write3, pc_write_cond3, branch_ne3, i_or_d3, mem_read3, mem_write3, ir_write3;
    logic        reg_dst3, mem_to_reg3, reg_write3, alu_src_a3;
    logic [1:0]  alu_src_b3, alu_op3, pc_source3;
    logic [3:0]  state3;
    logic        illegal_op3, mem_timeout3;
    logic [31:0] retired3;

    logic [16:0] ctrl;

    int tests_run;
    int tests_failed;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       last;
    } entry_t;

    entry_t     seq_q[$];
    logic [5:0] legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired(retired)
    );

    multicycle_control #(.WAIT_LIMIT(3)) dut3 (
        .clk(clk), .rst(rst3), .opcode(opcode3), .mem_ready(mem_ready3),
        .pc_write(pc_write3), .pc_write_cond(pc_write_cond3), .branch_ne(branch_ne3),
        .i_or_d(i_or_d3), .mem_read(mem_read3), .mem_write(mem_write3), .ir_write(ir_write3),
        .reg_dst(reg_dst3), .mem_to_reg(mem_to_reg3), .reg_write(reg_write3),
        .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3), .alu_op(alu_op3), .pc_source(pc_source3),
        .state(state3), .illegal_op(illegal_op3), .mem_timeout(mem_timeout3), .retired(retired3)
    );

    assign ctrl = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word expected in each micro-step, taken from the step descriptions.
    function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
        logic pw, pwc, bne, iod, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, bne, iod, mr, mw, irw, rd, m2r, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bne = (op == 6'h05); end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, bne, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int exp_states [3] = '{1, 6, 7};
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (ctrl !== 17'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_ctrl_zero: got %h expected 0", ctrl);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || retired !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_fetch: state=%0d mem_read=%b ir_write=%b retired=%0d expected 0/1/1/0",
                     state, mem_read, ir_write, retired);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (state !== 4'(exp_states[i])) begin
                tests_failed++;
                $display("[TB] FAIL rtype_seq[%0d]: state=%0d expected %0d", i, state, exp_states[i]);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (state !== 4'd0 || retired !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL rtype_retire: state=%0d retired=%0d expected 0/1", state, retired);
        end
    endtask

    task automatic test_lw_wait();
        logic rdy_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int rd_cycles = 0;
        int wb_pulses = 0;
        int bad_m2r = 0;
        do_reset();
        opcode = 6'h23;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy_pat[i];
            #1;
            if (mem_read && i_or_d) rd_cycles++;
            if (reg_write) begin
                wb_pulses++;
                if (mem_to_reg !== 1'b1) bad_m2r++;
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (rd_cycles != 4 || wb_pulses != 1 || bad_m2r != 0) begin
            tests_failed++;
            $display("[TB] FAIL lw_wait_ctrl: rd_cycles=%0d wb=%0d bad_m2r=%0d expected 4/1/0",
                     rd_cycles, wb_pulses, bad_m2r);
        end
        tests_run++;
        if (state !== 4'd0 || retired !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL lw_wait_latency: state=%0d retired=%0d expected 0/1", state, retired);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'h05, 6'h04};
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            @(negedge clk);
            @(negedge clk);
            #1;
            tests_run++;
            if (state !== 4'd8 || pc_write_cond !== 1'b1 || branch_ne !== (k == 0) ||
                alu_op !== 2'b01 || pc_source !== 2'b01) begin
                tests_failed++;
                $display("[TB] FAIL branch_%0h: state=%0d pwc=%b bne=%b alu_op=%b psrc=%b expected 8/1/%0d/01/01",
                         ops[k], state, pc_write_cond, branch_ne, alu_op, pc_source, (k == 0));
            end
            @(negedge clk);
            #1;
            tests_run++;
            if (state !== 4'd0 || retired !== 32'(k + 1)) begin
                tests_failed++;
                $display("[TB] FAIL branch_retire_%0h: state=%0d retired=%0d expected 0/%0d",
                         ops[k], state, retired, k + 1);
            end
        end
    endtask

    task automatic test_illegal();
        int bad = 0;
        do_reset();
        mem_ready = 1'b1;
        opcode = 6'h3F;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 4'd15 || illegal_op !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_halt: state=%0d illegal_op=%b expected 15/1", state, illegal_op);
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (state !== 4'd15 || ctrl !== 17'd0 || retired !== 32'd0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL halt_hold: %0d bad cycles expected 0", bad);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0 || illegal_op !== 1'b0 || retired !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_clear: state=%0d illegal_op=%b retired=%0d expected 0/0/0",
                     state, illegal_op, retired);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        rst3 = 1'b1; opcode3 = 6'h00; mem_ready3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (state3 !== 4'd0) bad++;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (bad != 0 || state3 !== 4'd15 || mem_timeout3 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_fire: bad=%0d state=%0d mem_timeout=%b expected 0/15/1",
                     bad, state3, mem_timeout3);
        end
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        tests_run++;
        if (mem_timeout3 !== 1'b0 || state3 !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_clear: mem_timeout=%b state=%0d expected 0/0", mem_timeout3, state3);
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready3 = (i == 3);
            #1;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (state3 !== 4'd1 || mem_timeout3 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_edge_ready: state=%0d mem_timeout=%b expected 1/0", state3, mem_timeout3);
        end
        rst3 = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        opcode = 6'h2B;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sw_wait: state=%0d mem_write=%b expected 5/1", state, mem_write);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (mem_write !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_drops_write: mem_write=%b expected 0", mem_write);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 4'd0 || retired !== 32'd0 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_write: state=%0d retired=%0d mem_write=%b expected 0/0/0",
                     state, retired, mem_write);
        end
        rst = 1'b0;
    endtask

    // Expands one memory access into its wait cycles followed by the completing cycle.
    task automatic push_access(input logic [3:0] st, input int waits, input logic last);
        for (int w = 0; w < waits; w++) seq_q.push_back('{st: st, rdy: 1'b0, last: 1'b0});
        seq_q.push_back('{st: st, rdy: 1'b1, last: last});
    endtask

    task automatic push_step(input logic [3:0] st, input logic last);
        seq_q.push_back('{st: st, rdy: 1'($urandom_range(0, 1)), last: last});
    endtask

    task automatic test_random_stream();
        logic [5:0] op;
        entry_t     e;
        int         exp_retired = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = legal_ops[$urandom_range(0, 6)];
            seq_q.delete();
            push_access(4'd0, $urandom_range(0, 4), 1'b0);
            push_step(4'd1, 1'b0);
            case (op)
                6'h23: begin
                    push_step(4'd2, 1'b0);
                    push_access(4'd3, $urandom_range(0, 4), 1'b0);
                    push_step(4'd4, 1'b1);
                end
                6'h2B: begin
                    push_step(4'd2, 1'b0);
                    push_access(4'd5, $urandom_range(0, 4), 1'b1);
                end
                6'h00: begin push_step(4'd6, 1'b0); push_step(4'd7, 1'b1); end
                6'h08: begin push_step(4'd10, 1'b0); push_step(4'd11, 1'b1); end
                6'h02: push_step(4'd9, 1'b1);
                default: push_step(4'd8, 1'b1);
            endcase
            while (seq_q.size() > 0) begin
                e = seq_q.pop_front();
                opcode = op;
                mem_ready = e.rdy;
                #1;
                tests_run++;
                if (state !== e.st || ctrl !== exp_ctrl(int'(e.st), op, e.rdy) ||
                    retired !== 32'(exp_retired)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_op%0h: state=%0d ctrl=%h retired=%0d expected %0d/%h/%0d",
                             op, state, ctrl, retired, e.st, exp_ctrl(int'(e.st), op, e.rdy), exp_retired);
                end
                @(negedge clk);
                if (e.last) exp_retired++;
            end
        end
        #1;
        tests_run++;
        if (retired !== 32'd40 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_final: retired=%0d illegal=%b timeout=%b expected 40/0/0",
                     retired, illegal_op, mem_timeout);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
        rst3 = 1'b1; opcode3 = 6'h00; mem_ready3 = 1'b0;
        @(negedge clk);
        test_reset();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing controller for the multicycle variant of the MIPS core.
- Replaces the single-cycle opcode decoder. It drives one shared instruction/data memory port, the IR, the register bank, the ALU source muxes and the PC update, one micro-step per cycle.
- It handles memory wait states through a ready handshake, with a watchdog timeout.
- It keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles a memory access may wait for mem_ready before a timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- opcode, input, 6: IR[31:26]; sampled in DECODE.
- mem_ready, input, 1: memory completes the current access this cycle.
- pc_write, output, 1: unconditional PC load.
- pc_write_cond, output, 1: PC load if the branch condition holds.
- branch_ne, output, 1: 1 = bne (condition is !Z); 0 = beq (condition is Z).
- i_or_d, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- mem_read, output, 1: memory read request.
- mem_write, output, 1: memory write request.
- ir_write, output, 1: IR load.
- reg_dst, output, 1: write address select; 0 = rt, 1 = rd.
- mem_to_reg, output, 1: write data select; 0 = ALUOut, 1 = MDR.
- reg_write, output, 1: register bank write enable.
- alu_src_a, output, 1: ALU A select; 0 = PC, 1 = A register.
- alu_src_b, output, 2: ALU B select; 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op, output, 2: 00 = add, 01 = sub, 10 = use funct.
- pc_source, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state, output, 4: current state encoding, for debug.
- illegal_op, output, 1: sticky; set when an unsupported opcode is decoded.
- mem_timeout, output, 1: sticky; set when the watchdog expires.
- retired, output, CNT_WIDTH: count of completed instructions.

Behaviour:
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11, HALT = 15
- Reset:
  - While rst = 1, all control outputs are forced to 0.
  - On the clock edge with rst = 1: state becomes FETCH; illegal_op, mem_timeout, retired and the wait counter clear.
  - Reset mid-access abandons the access with no write.
- Unlisted outputs are 0 in every state. Control outputs are combinational from the state, plus mem_ready where noted.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write equal mem_ready.
  - Goes to DECODE on mem_ready; otherwise stays.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode: 0x23 (lw) and 0x2B (sw) → MEM_ADDR; 0x00 → R_EXEC; 0x04 and 0x05 → BRANCH; 0x02 → JUMP; 0x08 → ADDI_EXEC.
  - Any other opcode → HALT, and illegal_op is set.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Goes to MEM_RD for lw, MEM_WR for sw. The opcode input stays stable while IR is unchanged.
- MEM_RD:
  - Outputs: mem_read = 1, i_or_d = 1.
  - Goes to MEM_WB on mem_ready.
- MEM_WB:
  - Outputs: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - Goes to FETCH; retire.
- MEM_WR:
  - Outputs: mem_write = 1, i_or_d = 1.
  - Goes to FETCH on mem_ready; retire.
- R_EXEC:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - Goes to R_WB.
- R_WB:
  - Outputs: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
  - Goes to FETCH; retire.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - branch_ne = 1 iff opcode = 0x05.
  - Goes to FETCH; retire.
- JUMP:
  - Outputs: pc_write = 1, pc_source = 10.
  - Goes to FETCH; retire.
- ADDI_EXEC:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Goes to ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - Goes to FETCH; retire.
- HALT: all control outputs 0; stays in HALT until rst.
- Retire:
  - retired increments by 1 on the edge leaving the last state of an instruction.
  - It wraps modulo 2^CNT_WIDTH.
- Watchdog:
  - The wait counter increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready = 0.
  - It clears on mem_ready = 1 and on any state change.
  - When the counter equals WAIT_LIMIT and mem_ready is still 0, the next state is HALT and mem_timeout is set.
  - If mem_ready is 1 in that same cycle, the access completes normally and there is no timeout.
- Latency with mem_ready tied to 1:
  - lw = 5 cycles; sw = 4; R-type = 4; addi = 4; beq/bne = 3; j = 3.
  - Each wait cycle adds 1.

Test Plan:
- rst held 2 cycles, mem_ready = 1, opcode = 0x00 → in the first cycle after reset, state = 0, mem_read = 1, ir_write = 1. State sequence 0, 1, 6, 7, 0; retired = 1 after 4 cycles.
- lw (0x23) with mem_ready low for 3 cycles in MEM_RD → mem_read and i_or_d held at 1 for 4 cycles. reg_write pulses exactly once, with mem_to_reg = 1; total 8 cycles.
- bne (0x05) → in BRANCH: pc_write_cond = 1, branch_ne = 1, alu_op = 01, pc_source = 01. beq (0x04) → branch_ne = 0.
- opcode = 0x3F → after DECODE, state = 15 and illegal_op = 1. Stays there for 20 cycles with all controls 0 and retired unchanged; rst clears everything.
- WAIT_LIMIT = 3, mem_ready = 0 in FETCH → HALT after 4 FETCH cycles with mem_timeout = 1. Repeat with mem_ready = 1 on the 4th FETCH cycle → normal DECODE, no timeout.
- rst asserted during MEM_WR while waiting → mem_write drops the same cycle. State = FETCH after the edge; retired = 0.
